// File: rtl/seq_mult_scheduler.sv
// Round-robin front end that shares one sequential signed multiplier core between
// NREQ requesters and returns each product, tagged with its requester ID, on a response channel.
module seq_mult_scheduler #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 33,
    localparam int IDW    = $clog2(NREQ),
    localparam int CW     = $clog2(LATENCY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_m,
    input  logic [NREQ*WIDTH-1:0] req_q,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [2*WIDTH-1:0]    resp_result,
    output logic                  mult_load,
    output logic [WIDTH-1:0]      mult_m,
    output logic [WIDTH-1:0]      mult_q,
    input  logic [2*WIDTH-1:0]    mult_result,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits for ready, and req_ready is a combinational grant strobe raised only in IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    state_t          state, state_n;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   cnt;
    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
        logic [IDW:0] s;
        s = {1'b0, base} + (IDW+1)'(off);
        if (s >= (IDW+1)'(NREQ))
            s = s - (IDW+1)'(NREQ);
        return s[IDW-1:0];
    endfunction

    // First valid requester at or after rr_ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = wrap_add(rr_ptr, unsigned'(i));
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state;
        req_ready  = '0;
        mult_load  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready = NREQ'(1) << grant_idx;
                    state_n   = LOAD;
                end
            end
            LOAD: begin
                mult_load = 1'b1;
                state_n   = RUN;
            end
            RUN: begin
                if (cnt == CNT_LAST)
                    state_n = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr      <= '0;
            cnt         <= '0;
            mult_m      <= '0;
            mult_q      <= '0;
            resp_id     <= '0;
            resp_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        mult_m  <= req_m[int'(grant_idx)*WIDTH +: WIDTH];
                        mult_q  <= req_q[int'(grant_idx)*WIDTH +: WIDTH];
                        resp_id <= grant_idx;
                        rr_ptr  <= wrap_add(grant_idx, 1);
                    end
                end
                LOAD: cnt <= '0;
                RUN: begin
                    cnt <= cnt + CW'(1);
                    // The core result is first stable on the LATENCY-th edge after the load edge.
                    if (cnt == CNT_LAST)
                        resp_result <= mult_result;
                end
                default: ;
            endcase
        end
    end

endmodule
